accumulator_sequencer: RTL and testbench



---
 rtl/accumulator_pkg.sv | 44 ++++
 rtl/accumulator_sequencer_alu.sv | 22 ++
 rtl/accumulator_sequencer.sv | 103 ++++++++++
 tb/tb_accumulator_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accumulator_pkg.sv
// Shared definitions for the accumulator CPU sequencer: opcodes, FSM state
// encoding and the ALU operation codes used in EXEC.
package accumulator_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_HALT  = 4'h7;
    localparam logic [3:0] OP_JUMP  = 4'h8;
    localparam logic [3:0] OP_JZ    = 4'h9;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b1000;
    localparam logic [3:0] ALU_OR  = 4'b1001;

    typedef enum logic [2:0] {
        S_HALT   = 3'd0,
        S_FETCH  = 3'd1,
        S_LATCH  = 3'd2,
        S_DECODE = 3'd3,
        S_READ   = 3'd4,
        S_EXEC   = 3'd5,
        S_WRITE  = 3'd6
    } state_t;

    // LOAD has no ALU operation; EXEC bypasses the ALU for it.
    function automatic logic [3:0] alu_op_for(input logic [3:0] opcode);
        logic [3:0] op;
        op = ALU_ADD;
        case (opcode)
            OP_SUB:  op = ALU_SUB;
            OP_AND:  op = ALU_AND;
            OP_OR:   op = ALU_OR;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/accumulator_sequencer_alu.sv
// 16-bit ALU used by the sequencer's EXEC state; arithmetic wraps modulo 2^16.
module accumulator_sequencer_alu
    import accumulator_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [15:0] operand1,
    input  logic [15:0] operand2,
    output logic [15:0] result
);

    always_comb begin
        result = operand1 + operand2;
        case (op)
            ALU_ADD: result = operand1 + operand2;
            ALU_SUB: result = operand1 - operand2;
            ALU_AND: result = operand1 & operand2;
            ALU_OR:  result = operand1 | operand2;
            default: result = operand1 + operand2;
        endcase
    end

endmodule

// File: rtl/accumulator_sequencer.sv
// Fetch/decode/execute controller for the 16-bit accumulator CPU. Owns PC, IR
// and AC and issues at most one main-memory request per cycle.
module accumulator_sequencer
    import accumulator_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] mem_rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic [15:0] pc,
    output logic [15:0] ir,
    output logic [15:0] ac,
    output logic        halted,
    output logic        illegal
);

    state_t      state;
    state_t      state_next;
    logic [3:0]  opcode;
    logic [15:0] operand_addr;
    logic [15:0] alu_result;

    assign opcode       = ir[15:12];
    assign operand_addr = {4'h0, ir[11:0]};

    accumulator_sequencer_alu u_alu (
        .op       (alu_op_for(opcode)),
        .operand1 (ac),
        .operand2 (mem_rdata),
        .result   (alu_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_HALT;
            pc      <= 16'h0000;
            ir      <= 16'h0000;
            ac      <= 16'h0000;
            illegal <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_HALT: begin
                    if (run) illegal <= 1'b0;
                end
                S_LATCH: begin
                    ir <= mem_rdata;
                    pc <= pc + 16'h0001;
                end
                S_DECODE: begin
                    case (opcode)
                        OP_NOP, OP_LOAD, OP_STORE, OP_ADD,
                        OP_SUB, OP_AND, OP_OR, OP_HALT: ;
                        OP_JUMP: pc <= operand_addr;
                        OP_JZ:   if (ac == 16'h0000) pc <= operand_addr;
                        default: illegal <= 1'b1;
                    endcase
                end
                S_EXEC: begin
                    ac <= (opcode == OP_LOAD) ? mem_rdata : alu_result;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_HALT:   if (run) state_next = S_FETCH;
            S_FETCH:  state_next = S_LATCH;
            S_LATCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR: state_next = S_READ;
                    OP_STORE:                     state_next = S_WRITE;
                    OP_NOP, OP_JUMP, OP_JZ:       state_next = S_FETCH;
                    default:                      state_next = S_HALT;
                endcase
            end
            S_READ:   state_next = S_EXEC;
            S_EXEC:   state_next = S_FETCH;
            S_WRITE:  state_next = S_FETCH;
            default:  state_next = S_HALT;
        endcase
    end

    // Moore memory port; the write strobe is masked by reset so a reset that
    // lands on a STORE can never corrupt memory.
    always_comb begin
        mem_addr  = pc;
        mem_wdata = ac;
        mem_we    = 1'b0;
        if (state == S_READ || state == S_WRITE) mem_addr = operand_addr;
        if (state == S_WRITE && !reset) mem_we = 1'b1;
    end

    assign halted = (state == S_HALT);

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Bench for accumulator_sequencer: directed programs plus random forward-only
// programs, checked against an instruction-level reference interpreter.
module tb_accumulator_sequencer;

    localparam int HW = 65;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [15:0] mem_rdata;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] pc;
    logic [15:0] ir;
    logic [15:0] ac;
    logic        halted;
    logic        illegal;

    accumulator_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .pc        (pc),
        .ir        (ir),
        .ac        (ac),
        .halted    (halted),
        .illegal   (illegal)
    );

    // ---------------- clock / memory responder ----------------
    always #5 clk = ~clk;

    logic [15:0] mem [0:65535];
    logic        ld_en = 1'b0;
    logic [15:0] ld_addr = 16'h0;
    logic [15:0] ld_data = 16'h0;

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    // ---------------- scoreboard state ----------------
    logic [31:0]   wr_q[$];
    logic [HW-1:0] exp_q[$];
    int compared = 0;
    int failed = 0;

    logic [15:0] mm [0:65535];
    logic [15:0] m_pc, m_ac, m_ir;
    logic        m_ill;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            failed++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_pc = 16'h0; m_ac = 16'h0; m_ir = 16'h0; m_ill = 1'b0;
    endtask

    // Executes from m_pc until HALT/illegal; queues every expected write and
    // the architectural state plus cycle count at the halt.
    task automatic model_run();
        int n = 0;
        logic [15:0] cycles = 16'd0;
        bit done = 0;
        logic [3:0] op;
        logic [15:0] x;
        m_ill = 1'b0;
        while (!done && n < 2000) begin
            m_ir = mm[m_pc];
            m_pc = m_pc + 16'd1;
            op = m_ir[15:12];
            x = {4'h0, m_ir[11:0]};
            n++;
            case (op)
                4'h0: cycles += 16'd3;
                4'h1: begin m_ac = mm[x]; cycles += 16'd5; end
                4'h2: begin mm[x] = m_ac; wr_q.push_back({x, m_ac}); cycles += 16'd4; end
                4'h3: begin m_ac = m_ac + mm[x]; cycles += 16'd5; end
                4'h4: begin m_ac = m_ac - mm[x]; cycles += 16'd5; end
                4'h5: begin m_ac = m_ac & mm[x]; cycles += 16'd5; end
                4'h6: begin m_ac = m_ac | mm[x]; cycles += 16'd5; end
                4'h7: begin cycles += 16'd3; done = 1; end
                4'h8: begin m_pc = x; cycles += 16'd3; end
                4'h9: begin if (m_ac == 16'h0) m_pc = x; cycles += 16'd3; end
                default: begin m_ill = 1'b1; cycles += 16'd3; done = 1; end
            endcase
        end
        exp_q.push_back({m_pc, m_ac, m_ir, m_ill, cycles});
    endtask

    // ---------------- monitor ----------------
    int            cyc = 0;
    int            start_cyc = 0;
    logic          prev_halted = 1'b1;
    logic          rst_prev = 1'b1;
    logic [31:0]   mon_w;
    logic [HW-1:0] mon_h;

    always @(negedge clk) begin
        cyc++;
        if (mem_we === 1'b1) begin
            if (wr_q.size() == 0) begin
                compared++; failed++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
            end else begin
                mon_w = wr_q.pop_front();
                check("write_addr", {16'h0, mem_addr}, {16'h0, mon_w[31:16]});
                check("write_data", {16'h0, mem_wdata}, {16'h0, mon_w[15:0]});
            end
        end
        if (halted === 1'b1 && prev_halted === 1'b0 && rst_prev === 1'b0) begin
            if (exp_q.size() == 0) begin
                compared++; failed++;
                $display("FAIL unexpected_halt: got halt with pc %h expected none", pc);
            end else begin
                mon_h = exp_q.pop_front();
                check("halt_pc", {16'h0, pc}, {16'h0, mon_h[64:49]});
                check("halt_ac", {16'h0, ac}, {16'h0, mon_h[48:33]});
                check("halt_ir", {16'h0, ir}, {16'h0, mon_h[32:17]});
                check("halt_illegal", {31'h0, illegal}, {31'h0, mon_h[16]});
                check("halt_cycles", cyc - start_cyc, {16'h0, mon_h[15:0]});
            end
        end
        if (halted === 1'b1 && run === 1'b1 && reset === 1'b0) start_cyc = cyc + 1;
        prev_halted = halted;
        rst_prev = reset;
    end

    // ---------------- driver tasks ----------------
    task automatic put(input logic [15:0] a, input logic [15:0] d);
        mm[a] = d;
        ld_addr = a; ld_data = d; ld_en = 1'b1;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic launch(input bit hold, input int n_halts);
        int seen = 0;
        int waited = 0;
        logic prev;
        run = 1'b1;
        @(posedge clk); #1;
        if (!hold) run = 1'b0;
        check("illegal_cleared_on_run", {31'h0, illegal}, 32'h0);
        prev = halted;
        while (seen < n_halts && waited < 4000) begin
            @(posedge clk); #1;
            waited++;
            if (halted && !prev) seen++;
            prev = halted;
        end
        run = 1'b0;
        if (seen < n_halts) begin
            compared++; failed++;
            $display("FAIL launch_timeout: got %0d halts expected %0d", seen, n_halts);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        check({name, "_writes_left"}, wr_q.size(), 32'h0);
        check({name, "_halts_left"}, exp_q.size(), 32'h0);
        wr_q.delete();
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int r;
        logic [15:0] w;

        // reset and run high together: reset wins
        reset = 1'b1; run = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", {16'h0, pc}, 32'h0);
        check("rst_ir", {16'h0, ir}, 32'h0);
        check("rst_ac", {16'h0, ac}, 32'h0);
        check("rst_halted", {31'h0, halted}, 32'h1);
        check("rst_illegal", {31'h0, illegal}, 32'h0);
        check("rst_mem_we", {31'h0, mem_we}, 32'h0);
        check("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
        check("rst_mem_wdata", {16'h0, mem_wdata}, 32'h0);
        reset = 1'b0; run = 1'b0;
        @(posedge clk); #1;
        check("idle_halted", {31'h0, halted}, 32'h1);
        model_reset();

        // straight-line program
        do_reset();
        put(16'h0, 16'h1010); put(16'h1, 16'h3011); put(16'h2, 16'h2012); put(16'h3, 16'h7000);
        put(16'h10, 16'd5); put(16'h11, 16'd7); put(16'h12, 16'h0);
        model_run();
        launch(0, 1);
        drain("straight");
        check("straight_mem12", {16'h0, mem[16'h12]}, 32'd12);

        // SUB wraps below zero
        do_reset();
        put(16'h0, 16'h1010); put(16'h1, 16'h4011); put(16'h2, 16'h7000);
        put(16'h10, 16'd3); put(16'h11, 16'd5);
        model_run();
        launch(0, 1);
        drain("sub_wrap");
        check("sub_wrap_ac", {16'h0, ac}, 32'h0000FFFE);

        // JZ taken, then not taken
        for (int k = 0; k < 2; k++) begin
            do_reset();
            put(16'h0, 16'h1010); put(16'h1, 16'h9020); put(16'h2, 16'h7000);
            put(16'h20, 16'h7000); put(16'h10, 16'(k));
            model_run();
            launch(0, 1);
            drain("jz");
        end

        // illegal opcode, then resume from the next word
        do_reset();
        put(16'h0, 16'hF123); put(16'h1, 16'h7000);
        model_run();
        launch(0, 1);
        drain("illegal");
        check("illegal_sticky", {31'h0, illegal}, 32'h1);
        model_run();
        launch(0, 1);
        drain("illegal_resume");

        // reset landing on the WRITE cycle of a STORE
        do_reset();
        put(16'h0, 16'h1010); put(16'h1, 16'h2030); put(16'h2, 16'h7000);
        put(16'h10, 16'h1234); put(16'h30, 16'hBEEF);
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("wr_rst_addr", {16'h0, mem_addr}, 32'h30);
        check("wr_rst_wdata", {16'h0, mem_wdata}, 32'h1234);
        reset = 1'b1;
        #1;
        check("wr_rst_we_masked", {31'h0, mem_we}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("wr_rst_pc", {16'h0, pc}, 32'h0);
        check("wr_rst_ac", {16'h0, ac}, 32'h0);
        check("wr_rst_ir", {16'h0, ir}, 32'h0);
        check("wr_rst_halted", {31'h0, halted}, 32'h1);
        check("wr_rst_mem", {16'h0, mem[16'h30]}, 32'hBEEF);
        model_reset();
        drain("wr_rst");

        // run held high through two HALTs
        do_reset();
        put(16'h0, 16'h1010); put(16'h1, 16'h7000); put(16'h2, 16'h3010); put(16'h3, 16'h7000);
        put(16'h10, 16'd9);
        model_run();
        model_run();
        launch(1, 2);
        drain("run_held");
        repeat (3) @(posedge clk);
        #1;
        check("run_held_stays_halted", {31'h0, halted}, 32'h1);
        check("run_held_pc", {16'h0, pc}, 32'h4);

        // random forward-only programs
        for (int t = 0; t < 24; t++) begin
            do_reset();
            put(16'h100, 16'h0);
            for (int a = 1; a < 16; a++) put(16'h100 + 16'(a), 16'($urandom));
            n = $urandom_range(4, 20);
            for (int i = 0; i < n; i++) begin
                if (i == n - 1) begin
                    w = 16'h7000;
                end else begin
                    r = $urandom_range(0, 19);
                    if (r < 10)
                        w = {4'($urandom_range(1, 6)), 8'h10, 4'($urandom_range(0, 15))};
                    else if (r < 12)
                        w = {4'h0, 12'($urandom)};
                    else if (r < 15)
                        w = {4'h8, 12'($urandom_range(i + 1, n - 1))};
                    else if (r < 18)
                        w = {4'h9, 12'($urandom_range(i + 1, n - 1))};
                    else if (r < 19)
                        w = {4'($urandom_range(10, 15)), 12'($urandom)};
                    else
                        w = 16'h7000;
                end
                put(16'(i), w);
            end
            model_run();
            launch(0, 1);
            drain("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
